// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-file responder; independent write/read FSMs.
// Optional read-only ID word at the top address: define AXI_REG_SLAVE_ID_EN.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic                    s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic                    s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ID_ADDR =
    {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] ID_WORD =
    DATA_WIDTH'(32'hA11E_0001);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) &&
           (int'(a[ADDR_WIDTH-1:2]) < NUM_REGS);
  endfunction

  function automatic logic is_id(input logic [ADDR_WIDTH-1:0] a);
`ifdef AXI_REG_SLAVE_ID_EN
    return a == ID_ADDR;
`else
    return (a == ID_ADDR) && 1'b0;
`endif
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic                  aw_full, aw_full_d;
  logic                  w_full, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;

  logic awready_d, wready_d, bvalid_d, bresp_d;
  logic arready_d, rvalid_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  aw_have, w_have;
  logic                  w_commit, w_ok, r_ok;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, r_val;
  logic [SW-1:0]         ws;
  logic [IW-1:0]         w_idx, r_idx;

  assign aw_hs   = s0_axi_awvalid && s0_axi_awready;
  assign w_hs    = s0_axi_wvalid && s0_axi_wready;
  assign ar_hs   = s0_axi_arvalid && s0_axi_arready;
  assign aw_have = aw_full || aw_hs;
  assign w_have  = w_full || w_hs;

  // A half arriving this cycle bypasses its holding register.
  assign wa = aw_hs ? s0_axi_awaddr : aw_addr_q;
  assign wd = w_hs ? s0_axi_wdata : w_data_q;
  assign ws = w_hs ? s0_axi_wstrb : w_strb_q;

  assign w_commit = (w_state == W_IDLE) && aw_have && w_have;
  assign w_ok     = legal(wa) && !is_id(wa);
  assign w_idx    = wa[IW+1:2];

  assign r_ok  = is_id(s0_axi_araddr) || legal(s0_axi_araddr);
  assign r_idx = s0_axi_araddr[IW+1:2];

  always_comb begin
    r_val = '0;
    if (is_id(s0_axi_araddr))
      r_val = ID_WORD;
    else if (legal(s0_axi_araddr))
      r_val = regs[r_idx];
  end

  // State registers
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
    end
  end

  // Next state
  always_comb begin
    w_state_d = w_state;
    unique case (w_state)
      W_IDLE: if (w_commit) w_state_d = W_RESP;
      W_RESP: if (s0_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (s0_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Next registered outputs
  always_comb begin
    aw_full_d = 1'b0;
    w_full_d  = 1'b0;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = s0_axi_bvalid;
    bresp_d   = s0_axi_bresp;
    unique case (w_state)
      W_IDLE: begin
        if (w_commit) begin
          bvalid_d = 1'b1;
          bresp_d  = !w_ok;
        end else begin
          aw_full_d = aw_have;
          w_full_d  = w_have;
          awready_d = !aw_have;
          wready_d  = !w_have;
        end
      end
      W_RESP: begin
        if (s0_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    arready_d = s0_axi_arready;
    rvalid_d  = s0_axi_rvalid;
    rdata_d   = s0_axi_rdata;
    rresp_d   = s0_axi_rresp;
    unique case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_val;
          rresp_d   = !r_ok;
        end
      end
      R_DATA: begin
        if (s0_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      s0_axi_awready <= 1'b0;
      s0_axi_wready  <= 1'b0;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_bresp   <= 1'b0;
      s0_axi_arready <= 1'b0;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rdata   <= '0;
      s0_axi_rresp   <= 1'b0;
    end else begin
      aw_full        <= aw_full_d;
      w_full         <= w_full_d;
      s0_axi_awready <= awready_d;
      s0_axi_wready  <= wready_d;
      s0_axi_bvalid  <= bvalid_d;
      s0_axi_bresp   <= bresp_d;
      s0_axi_arready <= arready_d;
      s0_axi_rvalid  <= rvalid_d;
      s0_axi_rdata   <= rdata_d;
      s0_axi_rresp   <= rresp_d;
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s0_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s0_axi_wdata;
        w_strb_q <= s0_axi_wstrb;
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (w_commit && w_ok) begin
      for (int b = 0; b < SW; b++)
        if (ws[b])
          regs[w_idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave.
// Honours AXI_REG_SLAVE_ID_EN when defined.
module tb_axi_lite_reg_slave;

  logic        s0_axi_aclk = 1'b0;
  logic        s0_axi_aresetn = 1'b0;
  logic [7:0]  s0_axi_awaddr = '0;
  logic        s0_axi_awvalid = 1'b0;
  logic        s0_axi_awready;
  logic [31:0] s0_axi_wdata = '0;
  logic [3:0]  s0_axi_wstrb = '0;
  logic        s0_axi_wvalid = 1'b0;
  logic        s0_axi_wready;
  logic        s0_axi_bresp;
  logic        s0_axi_bvalid;
  logic        s0_axi_bready = 1'b0;
  logic [7:0]  s0_axi_araddr = '0;
  logic        s0_axi_arvalid = 1'b0;
  logic        s0_axi_arready;
  logic [31:0] s0_axi_rdata;
  logic        s0_axi_rresp;
  logic        s0_axi_rvalid;
  logic        s0_axi_rready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 s0_axi_aclk = ~s0_axi_aclk;

  axi_lite_reg_slave dut (
    .s0_axi_aclk    (s0_axi_aclk),
    .s0_axi_aresetn (s0_axi_aresetn),
    .s0_axi_awaddr  (s0_axi_awaddr),
    .s0_axi_awvalid (s0_axi_awvalid),
    .s0_axi_awready (s0_axi_awready),
    .s0_axi_wdata   (s0_axi_wdata),
    .s0_axi_wstrb   (s0_axi_wstrb),
    .s0_axi_wvalid  (s0_axi_wvalid),
    .s0_axi_wready  (s0_axi_wready),
    .s0_axi_bresp   (s0_axi_bresp),
    .s0_axi_bvalid  (s0_axi_bvalid),
    .s0_axi_bready  (s0_axi_bready),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rresp   (s0_axi_rresp),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge s0_axi_aclk);
    #1;
  endtask

  task automatic wr(input string tag,
                    input logic [7:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    input logic exp_resp);
    s0_axi_awaddr  = a;
    s0_axi_wdata   = d;
    s0_axi_wstrb   = s;
    s0_axi_awvalid = 1'b1;
    s0_axi_wvalid  = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    check({tag, "_bvalid"}, 32'(s0_axi_bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(s0_axi_bresp), 32'(exp_resp));
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
    check({tag, "_after"},
          32'({s0_axi_awready, s0_axi_wready, s0_axi_bvalid}),
          32'b110);
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [31:0] exp_data,
                    input logic exp_resp);
    s0_axi_araddr  = a;
    s0_axi_arvalid = 1'b1;
    tick();
    s0_axi_arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(s0_axi_rvalid), 32'd1);
    check({tag, "_rdata"}, s0_axi_rdata, exp_data);
    check({tag, "_rresp"}, 32'(s0_axi_rresp), 32'(exp_resp));
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_rready = 1'b0;
    check({tag, "_rdone"},
          32'({s0_axi_arready, s0_axi_rvalid}), 32'b10);
  endtask

  initial begin
    // Reset held for 2 cycles
    tick();
    tick();
    check("rst_out",
          32'({s0_axi_awready, s0_axi_wready, s0_axi_arready,
               s0_axi_bvalid, s0_axi_bresp,
               s0_axi_rvalid, s0_axi_rresp}), 32'd0);
    check("rst_rdata", s0_axi_rdata, 32'd0);
    s0_axi_aresetn = 1'b1;
    #1;
    check("rst_rel_rdy",
          32'({s0_axi_awready, s0_axi_wready, s0_axi_arready}),
          32'b000);
    tick();
    check("rst_edge_rdy",
          32'({s0_axi_awready, s0_axi_wready, s0_axi_arready}),
          32'b111);

    // Same-cycle AW+W
    wr("w04", 8'h04, 32'h0000_001E, 4'hF, 1'b0);
    rd("r04", 8'h04, 32'h0000_001E, 1'b0);

    // W first, AW three cycles later, bready held low
    s0_axi_wdata  = 32'h0000_0025;
    s0_axi_wstrb  = 4'h1;
    s0_axi_wvalid = 1'b1;
    tick();
    s0_axi_wvalid = 1'b0;
    check("wfirst_rdy",
          32'({s0_axi_awready, s0_axi_wready}), 32'b10);
    tick();
    tick();
    check("wfirst_nob", 32'(s0_axi_bvalid), 32'd0);
    s0_axi_awaddr  = 8'h10;
    s0_axi_awvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    check("awlate_bresp",
          32'({s0_axi_bvalid, s0_axi_bresp}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bhold",
            32'({s0_axi_bvalid, s0_axi_awready, s0_axi_wready}),
            32'b100);
    end
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
    check("bhold_done",
          32'({s0_axi_bvalid, s0_axi_awready, s0_axi_wready}),
          32'b011);
    rd("r10", 8'h10, 32'h0000_0025, 1'b0);

    // Read data held stable while rready low
    s0_axi_araddr  = 8'h04;
    s0_axi_arvalid = 1'b1;
    tick();
    s0_axi_arvalid = 1'b0;
    s0_axi_araddr  = 8'h10;
    tick();
    tick();
    check("rhold",
          32'({s0_axi_rvalid, s0_axi_arready, s0_axi_rresp}),
          32'b100);
    check("rhold_data", s0_axi_rdata, 32'h0000_001E);
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_rready = 1'b0;

    // Byte strobes, zero strobe, last legal word
    wr("w08", 8'h08, 32'hAABB_CCDD, 4'h5, 1'b0);
    rd("r08", 8'h08, 32'h00BB_00DD, 1'b0);
    wr("w04z", 8'h04, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd("r04z", 8'h04, 32'h0000_001E, 1'b0);
    wr("w1c", 8'h1C, 32'h1234_5678, 4'hF, 1'b0);
    rd("r1c", 8'h1C, 32'h1234_5678, 1'b0);

    // Illegal addresses
    wr("w02", 8'h02, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("w20", 8'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd("r02", 8'h02, 32'h0, 1'b1);
    rd("r20", 8'h20, 32'h0, 1'b1);
    rd("r00_kept", 8'h00, 32'h0, 1'b0);
    rd("r04_kept", 8'h04, 32'h0000_001E, 1'b0);

    // Read and write commit to word 0 on the same edge
    s0_axi_awaddr  = 8'h00;
    s0_axi_wdata   = 32'hDEAD_BEEF;
    s0_axi_wstrb   = 4'hF;
    s0_axi_araddr  = 8'h00;
    s0_axi_awvalid = 1'b1;
    s0_axi_wvalid  = 1'b1;
    s0_axi_arvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    s0_axi_arvalid = 1'b0;
    check("rw_flags",
          32'({s0_axi_bvalid, s0_axi_bresp,
               s0_axi_rvalid, s0_axi_rresp}), 32'b1010);
    check("rw_old", s0_axi_rdata, 32'h0);
    s0_axi_bready = 1'b1;
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_bready = 1'b0;
    s0_axi_rready = 1'b0;
    rd("r00_new", 8'h00, 32'hDEAD_BEEF, 1'b0);

`ifdef AXI_REG_SLAVE_ID_EN
    rd("rid", 8'hFC, 32'hA11E_0001, 1'b0);
    wr("wid", 8'hFC, 32'h0, 4'hF, 1'b1);
    rd("rid2", 8'hFC, 32'hA11E_0001, 1'b0);
`else
    rd("rfc", 8'hFC, 32'h0, 1'b1);
    wr("wfc", 8'hFC, 32'h0, 4'hF, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
